data_sram_responder: RTL

Responder end of the SoC data-SRAM interface driven by the CPU core. It accepts `en`/`wen`/`addr`/`wdata` requests and returns `rdata` one cycle later. Requests are served from an internal word-organised RAM with byte-lane writes, or from a small memory-mapped register page: LED latch, free-running timer and synchronised switch inputs. It sits beside the core in the SoC top and stands in for the data memory plus configuration registers.

---
 rtl/data_sram_responder.sv | 103 ++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with byte-lane writes plus a small register page
// (LED latch, free-running timer, synchronised switches). Read data is registered.
module data_sram_responder #(
   parameter int          ADDR_WIDTH = 14,
   parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led
);

   localparam logic [15:0] OFF_LED   = 16'hF000;
   localparam logic [15:0] OFF_TIMER = 16'hF004;
   localparam logic [15:0] OFF_SW    = 16'hF008;

   logic [31:0] mem [2**ADDR_WIDTH];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] sw_meta_q, sw_sync_q;

   logic                  mmio_hit, rd_req, wr_req, ram_we;
   logic [15:0]           offset;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [31:0]           rd_val;
   logic                  unused_addr_lsb;

   assign mmio_hit        = (addr[31:16] == MMIO_BASE[31:16]);
   assign offset          = {addr[15:2], 2'b00};
   assign ram_idx         = addr[ADDR_WIDTH+1:2];
   assign rd_req          = en && (wen == 4'b0000);
   assign wr_req          = en && (wen != 4'b0000);
   assign ram_we          = wr_req && !mmio_hit;
   assign unused_addr_lsb = ^addr[1:0];

   always_comb begin
      rd_val = 32'h0;
      if (!mmio_hit) begin
         rd_val = mem[ram_idx];
      end else begin
         case (offset)
            OFF_LED:   rd_val = {16'h0, led_q};
            OFF_TIMER: rd_val = timer_q;
            OFF_SW:    rd_val = {16'h0, sw_sync_q};
            default:   rd_val = 32'h0;
         endcase
      end
   end

   // A timer write replaces the increment for that cycle; unwritten lanes keep the current value.
   always_comb begin
      rdata_d = rd_req ? rd_val : rdata_q;
      led_d   = led_q;
      timer_d = timer_q + 32'd1;
      if (wr_req && mmio_hit && offset == OFF_LED) begin
         for (int i = 0; i < 2; i++) begin
            if (wen[i]) led_d[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      if (wr_req && mmio_hit && offset == OFF_TIMER) begin
         timer_d = timer_q;
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) timer_d[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         timer_q   <= 32'h0;
         sw_meta_q <= 16'h0;
         sw_sync_q <= 16'h0;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         sw_meta_q <= switch_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = rdata_q;
   assign led   = led_q;

endmodule
